load_store_unit: RTL
====================

# load_store_unit

Multi-cycle data-memory access unit for the RV32I core. It sits directly downstream of the ALU and uses the ALU result as the effective address. It performs byte-lane alignment for stores and extract/extend for loads. It runs a request/acknowledge handshake with the data memory and returns load data to write-back.

## Interface
- XLEN, 32, datapath width; only 32 is supported (4 byte lanes).
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  issue request; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  XLEN  effective address (ALU result); sampled with start.
- wdata  in  XLEN  store data (rs2); sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: access completed.
- error  out  1  one-cycle pulse: misaligned or illegal funct3; never coincident with done.
- rdata  out  XLEN  extended load result; valid with done, held until next accepted start.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  write enable, valid while mem_req.
- mem_addr  out  XLEN  word address: {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  memory accepts/completes request in the same cycle.
- mem_rdata  in  XLEN  read word, valid in the mem_ack cycle.

## Operation
- States: IDLE, ACCESS, RESP.
  - IDLE, start=1, legal and aligned: latch operands and go to ACCESS.
  - IDLE, start=1, illegal or misaligned: go to RESP with the error flag set.
  - ACCESS: mem_req=1. On mem_ack, capture the load result and go to RESP.
  - RESP: pulse done or error for one cycle, then return to IDLE.
- start is ignored outside IDLE. mem_ack is ignored outside ACCESS.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - All other codes raise error.
- Misaligned conditions raise error with no memory request:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
- Byte enables:
  - B/BU: 0001 << addr[1:0].
  - H/HU: 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - W: 1111.
  - The same mem_be is driven for loads.
- Store data lane replication:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
  - mem_wdata = 0 for loads.
- Load result: shift mem_rdata right by 8*addr[1:0] and take the low byte or half.
  - Sign-extend for B and H.
  - Zero-extend for BU and HU.
  - W passes through.
- Stores leave rdata unchanged. Error responses leave rdata unchanged.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - State to IDLE.
  - busy, done, error, mem_req, mem_we = 0.
  - mem_addr, mem_be, mem_wdata, rdata = 0.
- Reset takes effect from any state, including mid-ACCESS. The pending request is abandoned, and a later mem_ack is ignored.
- All outputs are registered.
  - start accepted at edge 0: busy and mem_req are high after edge 0.
  - mem_ack sampled high at edge N: mem_req drops after edge N; done and rdata are valid after edge N and stay valid until edge N+1.
- Minimum latency: with mem_ack tied high, done appears one cycle after mem_req. That is 2 cycles from start to done.
- Error path: error is high for the single cycle following the accepting edge. No mem_req is issued.
- Back-to-back operation: start can be accepted at the edge that ends RESP? No. RESP → IDLE takes one edge; the next start is sampled in IDLE. Issue rate is at most one access per 3 cycles plus memory wait.
- mem_addr, mem_we, mem_be and mem_wdata are stable for the whole time mem_req is high.

## Test plan
- Reset mid-access: start an LW, hold mem_ack=0 for 3 cycles, pulse rst_n=0, then assert mem_ack=1 → all outputs are 0, no done, unit stays IDLE.
- SB, addr=0x1003, wdata=0x000000A5, mem_ack after 2 wait cycles → mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, mem_req held 3 cycles, one done pulse.
- LB, addr=0x2002, mem_rdata=0x12F45678 → rdata=0xFFFFFFF4. LBU at the same address → rdata=0x000000F4.
- LH, addr=0x2002, mem_rdata=0x80015678 → rdata=0xFFFF8001. LHU → 0x00008001. LW, addr=0x2000 → 0x80015678.
- Misaligned and illegal requests: LW addr=0x2001, SH addr=0x3, and a store with funct3=100 → error pulses one cycle after start, mem_req never rises, rdata is unchanged.
- start pulsed while busy, and mem_ack pulsed in IDLE → no second request, no spurious done; mem_ack tied high gives done exactly 2 cycles after start.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access unit.
// Aligns store data to byte lanes, extracts and extends load data, and runs a
// req/ack handshake with data memory. Illegal or misaligned requests answer
// with a one-cycle error pulse and never reach memory.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start, is_store, funct3,      request issue (sampled in IDLE only)
//   addr, wdata
//   busy, done, error, rdata      status and load result to write-back
//   mem_req, mem_we, mem_addr,    data-memory request channel
//   mem_be, mem_wdata
//   mem_ack, mem_rdata            data-memory acknowledge and read word
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_q, state_d;

  // Width code and byte offset kept for the load extract in ACCESS.
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;

  logic             busy_d, done_d, error_d, mem_req_d, mem_we_d;
  logic [XLEN-1:0]  rdata_d, mem_addr_d, mem_wdata_d;
  logic [LANES-1:0] mem_be_d;

  // Request decode.
  logic             legal_c, misaligned_c;
  logic [LANES-1:0] be_c;
  logic [XLEN-1:0]  wrep_c;
  // Load extract.
  logic [XLEN-1:0]  shifted_c, load_c;

  // Legality, alignment, lane enables and store replication of the request.
  always_comb begin
    legal_c      = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                            : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be_c   = 4'b0001 << addr[1:0];
        wrep_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c   = addr[1] ? 4'b1100 : 4'b0011;
        wrep_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c   = 4'b1111;
        wrep_c = wdata;
      end
    endcase
  end

  // Shift the read word down to the accessed lane, then size and extend.
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  load_c = {24'd0, shifted_c[7:0]};
      3'b101:  load_c = {16'd0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = 1'b0;
    rdata_d     = rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (legal_c && !misaligned_c) begin
            state_d     = ACCESS;
            f3_d        = funct3;
            off_d       = addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = is_store ? wrep_c : '0;
          end else begin
            state_d = RESP;
            error_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we) rdata_d = load_c;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      rdata     <= rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule
